// File: rtl/sirv_reset_sequencer_if.sv
// sirv_reset_sequencer_if: reset request/release bundle between reset sources and domains
interface sirv_reset_sequencer_if #(parameter int NCH = 4);
  logic           test_mode;
  logic           test_rst_i;
  logic [NCH-1:0] req_i;
  logic [NCH-1:0] rst_o;
  logic           busy_o;
  modport master (output test_mode, test_rst_i, req_i, input rst_o, busy_o);
  modport slave  (input test_mode, test_rst_i, req_i, output rst_o, busy_o);
endinterface

// File: rtl/sirv_reset_sequencer.sv
// sirv_reset_sequencer: catch async reset requests, stretch, then release domains in index order
module sirv_reset_sequencer #(
  parameter int NCH        = 4,
  parameter int SYNC_DEPTH = 3,
  parameter int STRETCH    = 16,
  parameter int GAP        = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  sirv_reset_sequencer_if.slave bus
);
  localparam int MX = STRETCH > GAP ? STRETCH : GAP;
  localparam int CW = $clog2(MX + 1);
  localparam int IW = $clog2(NCH + 1);
  localparam logic [CW-1:0] S_LAST = CW'(STRETCH - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NCH - 1);
  typedef enum logic [1:0] {HOLD, RELEASE, IDLE} state_t;
  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [IW-1:0]         idx, idx_d;
  logic [NCH-1:0]        rst_q, rst_d;
  logic                  busy, req_s;
  logic [SYNC_DEPTH-1:0] sync_q [NCH];
  // chains reset to 1 so a request pending across rst_n is never lost
  always_ff @(posedge clk)
    for (int i = 0; i < NCH; i++)
      sync_q[i] <= !rst_n ? '1 : {sync_q[i][SYNC_DEPTH-2:0], bus.req_i[i]};
  always_comb begin
    req_s = 1'b0;
    for (int i = 0; i < NCH; i++) req_s |= sync_q[i][SYNC_DEPTH-1];
  end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    rst_d   = rst_q;
    if (req_s) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
    end else begin
      case (state)
        HOLD: begin
          rst_d = '1;
          cnt_d = cnt + CW'(1);
          if (cnt == S_LAST) begin
            rst_d   = ~NCH'(1);
            idx_d   = IW'(1);
            cnt_d   = '0;
            state_d = NCH == 1 ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          cnt_d = cnt + CW'(1);
          if (cnt == G_LAST) begin
            rst_d   = rst_q & ~(NCH'(1) << idx);
            idx_d   = idx + IW'(1);
            cnt_d   = '0;
            state_d = idx == I_LAST ? IDLE : RELEASE;
          end
        end
        default: rst_d = '0;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HOLD;
      cnt   <= '0;
      idx   <= '0;
      rst_q <= '1;
      busy  <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      rst_q <= rst_d;
      busy  <= |rst_d;
    end
  end
  // test bypass is purely combinational so scan reset reaches domains without a clock
  assign bus.rst_o  = bus.test_mode ? {NCH{bus.test_rst_i}} : rst_q;
  assign bus.busy_o = busy;
endmodule

// File: tb/tb_sirv_reset_sequencer.sv
// tb_sirv_reset_sequencer: directed checks of release timing, request catch and test bypass
module tb_sirv_reset_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ed = 0;
  int   e, f, g;
  sirv_reset_sequencer_if #(.NCH(4)) bus ();
  sirv_reset_sequencer_if #(.NCH(1)) sb ();
  sirv_reset_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  sirv_reset_sequencer #(.NCH(1), .SYNC_DEPTH(2), .STRETCH(1), .GAP(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(sb.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    ed++;
  endtask
  task automatic run_to(input int n);
    while (ed < n) tick();
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, ed);
    end
  endtask
  task automatic chk4(input string tag, input logic [3:0] r, input logic b);
    chk({tag, "_rst"}, 32'(bus.rst_o), 32'(r));
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'(b));
  endtask
  initial begin
    bus.req_i = '0; bus.test_mode = 1'b0; bus.test_rst_i = 1'b0;
    sb.req_i = '0; sb.test_mode = 1'b0; sb.test_rst_i = 1'b0;
    tick(); tick();
    chk4("in_reset", 4'hF, 1'b1);
    chk("sw_in_reset", 32'(sb.rst_o), 32'd1);
    rst_n = 1'b1; ed = 0;
    run_to(2); chk("sw_e2", 32'({sb.rst_o, sb.busy_o}), 32'b11);
    run_to(3); chk("sw_e3", 32'({sb.rst_o, sb.busy_o}), 32'b00);
    run_to(18); chk4("pu_e18", 4'hF, 1'b1);
    run_to(19); chk4("pu_e19", 4'hE, 1'b1);
    run_to(26); chk4("pu_e26", 4'hE, 1'b1);
    run_to(27); chk4("pu_e27", 4'hC, 1'b1);
    run_to(34); chk4("pu_e34", 4'hC, 1'b1);
    run_to(35); chk4("pu_e35", 4'h8, 1'b1);
    run_to(42); chk4("pu_e42", 4'h8, 1'b1);
    run_to(43); chk4("pu_e43", 4'h0, 1'b0);
    run_to(45);
    e = ed + 1; bus.req_i = 4'b0100; tick(); bus.req_i = '0;
    run_to(e + 2);  chk4("pulse_e2", 4'h0, 1'b0);
    run_to(e + 3);  chk4("pulse_e3", 4'hF, 1'b1);
    run_to(e + 18); chk4("pulse_e18", 4'hF, 1'b1);
    run_to(e + 19); chk4("pulse_e19", 4'hE, 1'b1);
    run_to(e + 27); chk4("pulse_e27", 4'hC, 1'b1);
    f = ed + 1; bus.req_i = 4'b0001; tick(); bus.req_i = '0;
    run_to(f + 2);  chk4("rel_f2", 4'hC, 1'b1);
    run_to(f + 3);  chk4("rel_f3", 4'hF, 1'b1);
    run_to(f + 18); chk4("rel_f18", 4'hF, 1'b1);
    run_to(f + 19); chk4("rel_f19", 4'hE, 1'b1);
    run_to(f + 43); chk4("rel_f43", 4'h0, 1'b0);
    for (int t = 0; t <= 109; t++) begin
      bus.req_i = (t % 10 == 0 && t <= 90) ? 4'b1000 : 4'b0000;
      tick();
      if (t >= 3) chk("rep_rst", 32'(bus.rst_o), t == 109 ? 32'hE : 32'hF);
    end
    bus.req_i = '0;
    run_to(ed + 24); chk4("rep_done", 4'h0, 1'b0);
    bus.test_mode = 1'b1; bus.test_rst_i = 1'b1; #1;
    chk4("tm_hi_idle", 4'hF, 1'b0);
    bus.test_rst_i = 1'b0; #1;
    chk4("tm_lo_idle", 4'h0, 1'b0);
    g = ed + 1; bus.req_i = 4'b0010; tick(); bus.req_i = '0;
    run_to(g + 3); chk4("tm_lo_hold", 4'h0, 1'b1);
    bus.test_rst_i = 1'b1; #1;
    chk4("tm_hi_hold", 4'hF, 1'b1);
    bus.test_mode = 1'b0; bus.test_rst_i = 1'b0; #1;
    chk4("tm_off_hold", 4'hF, 1'b1);
    run_to(g + 27); chk4("tm_seq_g27", 4'hC, 1'b1);
    rst_n = 1'b0; tick();
    chk4("mid_reset", 4'hF, 1'b1);
    rst_n = 1'b1; ed = 0;
    run_to(3);  chk("sw_re3", 32'({sb.rst_o, sb.busy_o}), 32'b00);
    run_to(18); chk4("re_e18", 4'hF, 1'b1);
    run_to(19); chk4("re_e19", 4'hE, 1'b1);
    run_to(43); chk4("re_e43", 4'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
